sr_latch_driver: RTL and testbench

Synchronous sequencer that drives the gated S/R/E inputs of an external set-reset latch and confirms the stored value through the latch's Q/Q_n feedback. A requester hands it a one-bit target value over a valid/ready handshake. The block emits a clean, never-forbidden S or R pulse qualified by E, waits a settle window, then samples the latch outputs and reports done or error. It sits between clocked control logic and asynchronous latch storage, so no requester ever drives S/R directly.

---
 rtl/sr_latch_driver.sv | 139 +++++++++++++
 tb/tb_sr_latch_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Sequencer driving the S/R/E inputs of an external SR latch and confirming the stored value via Q/Q_n.
// Optional feedback synchronizers and mismatch check: define SR_LATCH_DRIVER_VERIFY_EN.
module sr_latch_driver #(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 3,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  output logic lat_s,
  output logic lat_r,
  output logic lat_e,
  input  logic lat_q,
  input  logic lat_qn,
  output logic done,
  output logic err,
  output logic q_state
);

  localparam int P_EFF = (PULSE_W < 1) ? 1 : PULSE_W;
  localparam int S_EFF = (SETTLE_W < 2) ? 2 : SETTLE_W;
  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(P_EFF);
  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             val;
  logic             fb_err;

`ifdef SR_LATCH_DRIVER_VERIFY_EN
  logic sync_q1, sync_q2, sync_qn1, sync_qn2;
  logic err_r;

  // Latch outputs are asynchronous to clk, so only the second flop is trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      sync_qn1 <= 1'b0;
      sync_qn2 <= 1'b0;
    end else begin
      sync_q1  <= lat_q;
      sync_q2  <= sync_q1;
      sync_qn1 <= lat_qn;
      sync_qn2 <= sync_qn1;
    end
  end

  assign fb_err = (sync_q2 != val) || (sync_q2 == sync_qn2);
  assign err    = err_r;
`else
  logic unused_fb;
  assign unused_fb = lat_q ^ lat_qn;
  assign fb_err    = 1'b0;
  assign err       = 1'b0;
`endif

  // Outputs are set on the edge that enters each phase so they are glitch-free registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      val       <= 1'b0;
      req_ready <= 1'b1;
      lat_s     <= 1'b0;
      lat_r     <= 1'b0;
      lat_e     <= 1'b0;
      done      <= 1'b0;
      q_state   <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      err_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      err_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            val       <= req_val;
            state     <= DRIVE;
            cnt       <= P_LOAD;
            req_ready <= 1'b0;
            lat_e     <= 1'b1;
            lat_s     <= req_val;
            lat_r     <= ~req_val;
          end
        end
        DRIVE: begin
          if (cnt == CNT_ONE) begin
            state <= SETTLE;
            cnt   <= S_LOAD;
            lat_e <= 1'b0;
            lat_s <= 1'b0;
            lat_r <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_ONE) begin
            state   <= CHECK;
            cnt     <= '0;
            done    <= 1'b1;
            q_state <= val;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            err_r   <= fb_err;
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        CHECK: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          req_ready <= 1'b1;
          lat_e     <= 1'b0;
          lat_s     <= 1'b0;
          lat_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: latch model with 1-cycle delay, transaction-level reference model, directed and random stimulus.
module tb_sr_latch_driver;

  localparam int P = 2;
  localparam int S = 3;
  localparam int CHECK_AT = P + S + 1;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_ready, lat_s, lat_r, lat_e, done, err, q_state;
  logic lat_q = 1'b0;
  logic lat_qn = 1'b1;

  int errors = 0;
  int checks = 0;
  bit run_checks = 1'b0;
  int latch_mode = 0;

  sr_latch_driver #(.PULSE_W(P), .SETTLE_W(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_val(req_val), .lat_s(lat_s), .lat_r(lat_r), .lat_e(lat_e),
    .lat_q(lat_q), .lat_qn(lat_qn), .done(done), .err(err), .q_state(q_state)
  );

  always #5 clk = ~clk;

  // Latch model: 0 = healthy SR latch, 1 = stuck Q=0/Q_n=1, 2 = Q=Q_n=1.
  always @(posedge clk) begin
    case (latch_mode)
      1: begin lat_q <= 1'b0; lat_qn <= 1'b1; end
      2: begin lat_q <= 1'b1; lat_qn <= 1'b1; end
      default: begin
        if (lat_e && lat_s) begin lat_q <= 1'b1; lat_qn <= 1'b0; end
        else if (lat_e && lat_r) begin lat_q <= 1'b0; lat_qn <= 1'b1; end
      end
    endcase
  end

  // Reference model: phase counts cycles since the accepting edge; 0 means idle.
  int phase = 0;
  bit m_val = 1'b0;
  bit m_q = 1'b0;
  bit m_err = 1'b0;
  bit s1q = 0, s2q = 0, s1qn = 0, s2qn = 0;

  always @(posedge clk) begin
    bit fe;
    if (rst) begin
      phase = 0; m_q = 0; m_err = 0;
      s1q = 0; s2q = 0; s1qn = 0; s2qn = 0;
    end else begin
      fe = (s2q != m_val) || (s2q == s2qn);
      if (phase == 0) begin
        if (req_valid) begin phase = 1; m_val = req_val; end
      end else if (phase == CHECK_AT) begin
        phase = 0;
      end else begin
        phase = phase + 1;
        if (phase == CHECK_AT) begin
          m_q = m_val;
          m_err = VERIFY ? fe : 1'b0;
        end
      end
      s2q = s1q; s1q = lat_q;
      s2qn = s1qn; s1qn = lat_qn;
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_checks) begin
      bit drv, chk;
      drv = (phase >= 1) && (phase <= P);
      chk = (phase == CHECK_AT);
      checkOutput("req_ready", req_ready, phase == 0);
      checkOutput("lat_e", lat_e, drv);
      checkOutput("lat_s", lat_s, drv && m_val);
      checkOutput("lat_r", lat_r, drv && !m_val);
      checkOutput("done", done, chk);
      checkOutput("err", err, chk && m_err);
      checkOutput("q_state", q_state, m_q);
      checkOutput("sr_exclusive", !(lat_s && lat_r), 1'b1);
      checkOutput("sr_implies_e", !(lat_s || lat_r) || lat_e, 1'b1);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit v);
    req_valid = 1'b1;
    req_val = v;
    step(1);
    req_valid = 1'b0;
  endtask

  initial begin
    step(1);
    run_checks = 1'b1;
    step(1);
    @(negedge clk);
    checkOutput("rst_ready", req_ready, 1'b1);
    checkOutput("rst_lat_e", lat_e, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_q_state", q_state, 1'b0);
    #1 rst = 1'b0;
    step(1);

    // Set request at cycle 0, then valid held with val=0 for a back-to-back reset.
    req_valid = 1'b1; req_val = 1'b1;
    step(1);
    req_val = 1'b0;
    @(negedge clk);
    checkOutput("set_c1_lat_s", lat_s, 1'b1);
    checkOutput("set_c1_lat_e", lat_e, 1'b1);
    checkOutput("set_c1_lat_r", lat_r, 1'b0);
    step(1);
    @(negedge clk);
    checkOutput("set_c2_lat_s", lat_s, 1'b1);
    step(4);
    @(negedge clk);
    checkOutput("set_c6_done", done, 1'b1);
    checkOutput("set_c6_err", err, 1'b0);
    checkOutput("set_c6_q_state", q_state, 1'b1);
    step(1);
    @(negedge clk);
    checkOutput("b2b_c7_ready", req_ready, 1'b1);
    step(1);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_c8_lat_r", lat_r, 1'b1);
    checkOutput("b2b_c8_lat_s", lat_s, 1'b0);
    step(1);
    @(negedge clk);
    checkOutput("b2b_c9_lat_r", lat_r, 1'b1);
    step(4);
    @(negedge clk);
    checkOutput("b2b_c13_done", done, 1'b1);
    checkOutput("b2b_c13_q_state", q_state, 1'b0);
    step(1);

    // Latch stuck at Q=0 with a set request.
    latch_mode = 1;
    applyStimulus(1'b1);
    step(5);
    @(negedge clk);
    checkOutput("stuck_done", done, 1'b1);
    checkOutput("stuck_err", err, VERIFY);
    checkOutput("stuck_q_state", q_state, 1'b1);
    step(2);

    // Latch with Q=Q_n=1.
    latch_mode = 2;
    applyStimulus(1'b0);
    step(5);
    @(negedge clk);
    checkOutput("both_err", err, VERIFY);
    step(2);

    // Reset during DRIVE.
    latch_mode = 0;
    applyStimulus(1'b1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_lat_e", lat_e, 1'b0);
    checkOutput("abort_lat_s", lat_s, 1'b0);
    checkOutput("abort_ready", req_ready, 1'b1);
    checkOutput("abort_q_state", q_state, 1'b0);
    step(8);

    for (int i = 0; i < 600; i++) begin
      if (i % 10 == 0) begin
        int r;
        r = $urandom_range(0, 7);
        latch_mode = (r == 6) ? 1 : (r == 7) ? 2 : 0;
      end
      req_valid = ($urandom_range(0, 2) != 0);
      req_val = $urandom_range(0, 1);
      rst = ($urandom_range(0, 49) == 0);
      step(1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
